// File: rtl/alu_seq_pkg.sv
// Shared state encodings, opcode constants and the select-switch decoder
// for the front-panel ALU operation sequencer.
package alu_seq_pkg;

    localparam logic [2:0] ST_LOAD_A  = 3'd0;
    localparam logic [2:0] ST_LOAD_B  = 3'd1;
    localparam logic [2:0] ST_LOAD_OP = 3'd2;
    localparam logic [2:0] ST_EXEC    = 3'd3;
    localparam logic [2:0] ST_SHOW    = 3'd4;

    localparam logic [3:0] OP_0  = 4'd0;
    localparam logic [3:0] OP_1  = 4'd1;
    localparam logic [3:0] OP_2  = 4'd2;
    localparam logic [3:0] OP_3  = 4'd3;
    localparam logic [3:0] OP_4  = 4'd4;
    localparam logic [3:0] OP_8  = 4'd8;
    localparam logic [3:0] OP_9  = 4'd9;
    localparam logic [3:0] OP_10 = 4'd10;
    localparam logic [3:0] OP_11 = 4'd11;
    localparam logic [3:0] OP_12 = 4'd12;

    // Returns {valid, op}; sel[4:0] must contain exactly one zero, sel[5] picks the upper bank.
    function automatic logic [4:0] decode_sel(input logic [5:0] sel);
        logic [4:0] r;
        r = 5'b0_0000;
        case (sel[4:0])
            5'b01111: r = {1'b1, sel[5] ? OP_8  : OP_0};
            5'b10111: r = {1'b1, sel[5] ? OP_9  : OP_1};
            5'b11011: r = {1'b1, sel[5] ? OP_10 : OP_2};
            5'b11101: r = {1'b1, sel[5] ? OP_11 : OP_3};
            5'b11110: r = {1'b1, sel[5] ? OP_12 : OP_4};
            default:  r = 5'b0_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_btn_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debounce on a stable-sample
// count, and a one-cycle pulse on each accepted press (high->low) edge.
module btn_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press_p
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Counter tracks consecutive samples that disagree with the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_p <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            press_p <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_p <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Front-panel sequencer: latches A, B and opcode on successive step presses,
// fires one ALU start pulse, then captures result/flags for display.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned ALU_LATENCY     = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step_n,
    input  logic             btn_clr_n,
    input  logic [WIDTH-1:0] data_sw,
    input  logic [5:0]       sel_sw,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    output logic             alu_start,
    output logic [WIDTH-1:0] result_out,
    output logic [3:0]       flags_out,
    output logic             result_valid,
    output logic             op_err,
    output logic [2:0]       state_out
);

    localparam int unsigned LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY - 1);

    logic             step_p;
    logic             clr_p;
    logic [4:0]       dec;
    logic [2:0]       state_q, state_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [WIDTH-1:0] a_d, b_d, res_d;
    logic [3:0]       op_d, flg_d;
    logic             start_d, valid_d, err_d;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n   (btn_step_n),
        .press_p (step_p)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n   (btn_clr_n),
        .press_p (clr_p)
    );

    assign dec       = decode_sel(sel_sw);
    assign state_out = state_q;

    // Next-state and next-output logic; abort has priority over everything.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        a_d     = alu_a;
        b_d     = alu_b;
        op_d    = alu_op;
        res_d   = result_out;
        flg_d   = flags_out;
        err_d   = op_err;
        start_d = 1'b0;
        if (clr_p) begin
            state_d = ST_LOAD_A;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (step_p) begin
                        a_d     = data_sw;
                        state_d = ST_LOAD_B;
                    end
                end
                ST_LOAD_B: begin
                    if (step_p) begin
                        b_d     = data_sw;
                        state_d = ST_LOAD_OP;
                    end
                end
                ST_LOAD_OP: begin
                    if (step_p) begin
                        if (dec[4]) begin
                            op_d    = dec[3:0];
                            err_d   = 1'b0;
                            start_d = 1'b1;
                            state_d = ST_EXEC;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    // Count is loaded during the start cycle, so capture lands ALU_LATENCY cycles after it.
                    if (alu_start) begin
                        lat_d = LAT_LOAD;
                    end else if (lat_q != '0) begin
                        lat_d = lat_q - LAT_W'(1);
                    end else begin
                        res_d   = alu_result;
                        flg_d   = alu_flags;
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (step_p) state_d = ST_LOAD_A;
                end
                default: state_d = ST_LOAD_A;
            endcase
        end
        valid_d = (state_d == ST_SHOW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD_A;
            lat_q        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_start    <= 1'b0;
            result_out   <= '0;
            flags_out    <= '0;
            result_valid <= 1'b0;
            op_err       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            alu_a        <= a_d;
            alu_b        <= b_d;
            alu_op       <= op_d;
            alu_start    <= start_d;
            result_out   <= res_d;
            flags_out    <= flg_d;
            result_valid <= valid_d;
            op_err       <= err_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed front-panel scenarios
// followed by random presses, checked against a transaction-level model.
module tb_alu_op_sequencer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEB   = 4;

    localparam int S_A = 0, S_B = 1, S_OP = 2, S_EXEC = 3, S_SHOW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             btn_step_n, btn_clr_n;
    logic [WIDTH-1:0] data_sw;
    logic [5:0]       sel_sw;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic [WIDTH-1:0] alu_a, alu_b, result_out;
    logic [3:0]       alu_op, flags_out;
    logic             alu_start, result_valid, op_err;
    logic [2:0]       state_out;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(WIDTH), .ALU_LATENCY(LAT), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .btn_step_n(btn_step_n), .btn_clr_n(btn_clr_n),
        .data_sw(data_sw), .sel_sw(sel_sw), .alu_result(alu_result), .alu_flags(alu_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .result_out(result_out), .flags_out(flags_out), .result_valid(result_valid),
        .op_err(op_err), .state_out(state_out)
    );

    // Reference ALU behaviour: returns {N,Z,C,V,result}.
    function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        int s;
        logic [3:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin
                s = int'(a) + int'(b);
                r = 4'(s);
                c = (s > 15);
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin r = a - b; c = (a < b); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a ^ b ^ op;
        endcase
        return {r[3], (r == 4'd0), c, v, r};
    endfunction

    // ALU stub: two-register pipeline whose output is only meaningful on the capture cycle.
    logic [7:0] s1 = 8'h00, s2 = 8'h00;
    always @(posedge clk) begin
        s1 <= alu_start ? ref_alu(alu_a, alu_b, alu_op) : 8'h00;
        s2 <= s1;
    end
    assign alu_result = s2[3:0];
    assign alu_flags  = s2[7:4];

    // Observation monitor on the ALU handshake.
    int   cyc = 0, start_cyc = 0, last_lat = 0, starts = 0, start_double = 0, rv_rises = 0;
    logic start_prev = 1'b0, rv_prev = 1'b0;
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (alu_start) begin
            starts = starts + 1;
            start_cyc = cyc;
            if (start_prev) start_double = start_double + 1;
        end
        if (result_valid && !rv_prev) begin
            rv_rises = rv_rises + 1;
            last_lat = cyc - start_cyc;
        end
        start_prev = alu_start;
        rv_prev    = result_valid;
    end

    int n_assert = 0, n_fail = 0;

    // Transaction-level model of the panel.
    int         m_state, m_starts;
    logic [3:0] m_a, m_b, m_op, m_res, m_flg;
    logic       m_valid, m_err;

    function automatic logic [4:0] model_decode(input logic [5:0] sel);
        int zeros, pos;
        zeros = 0;
        pos   = 0;
        for (int i = 0; i < 5; i++) begin
            if (!sel[i]) begin
                zeros = zeros + 1;
                pos   = i;
            end
        end
        if (zeros != 1) return 5'd0;
        return {1'b1, 4'((sel[5] ? 8 : 0) + (4 - pos))};
    endfunction

    task automatic model_reset();
        m_state = S_A; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flg = 0;
        m_valid = 0; m_err = 0;
    endtask

    task automatic model_step();
        logic [4:0] d;
        logic [7:0] r;
        case (m_state)
            S_A: begin m_a = data_sw; m_state = S_B; end
            S_B: begin m_b = data_sw; m_state = S_OP; end
            S_OP: begin
                d = model_decode(sel_sw);
                if (d[4]) begin
                    m_op = d[3:0]; m_err = 0; m_starts = m_starts + 1;
                    r = ref_alu(m_a, m_b, m_op);
                    m_res = r[3:0]; m_flg = r[7:4];
                    m_valid = 1; m_state = S_SHOW;
                end else begin
                    m_err = 1;
                end
            end
            default: begin m_state = S_A; m_valid = 0; end
        endcase
    endtask

    task automatic model_clr();
        m_state = S_A; m_valid = 0; m_err = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_state"}, 32'(state_out), 32'(m_state));
        check({tag, "_a"}, 32'(alu_a), 32'(m_a));
        check({tag, "_b"}, 32'(alu_b), 32'(m_b));
        check({tag, "_op"}, 32'(alu_op), 32'(m_op));
        check({tag, "_err"}, 32'(op_err), 32'(m_err));
        check({tag, "_valid"}, 32'(result_valid), 32'(m_valid));
        check({tag, "_res"}, 32'(result_out), 32'(m_res));
        check({tag, "_flags"}, 32'(flags_out), 32'(m_flg));
        check({tag, "_starts"}, 32'(starts), 32'(m_starts));
        check({tag, "_start_width"}, 32'(start_double), 32'd0);
        if (m_valid) check({tag, "_latency"}, 32'(last_lat), 32'(LAT + 1));
    endtask

    task automatic press(input logic step, input logic clr, input int hold);
        if (step) btn_step_n = 1'b0;
        if (clr)  btn_clr_n  = 1'b0;
        repeat (hold) @(negedge clk);
        btn_step_n = 1'b1;
        btn_clr_n  = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] d;
        logic [4:0] s5;
        int saved_rises, k, r;

        rst_n = 1'b0; btn_step_n = 1'b1; btn_clr_n = 1'b1;
        data_sw = '0; sel_sw = 6'h3F;
        m_starts = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        check("reset_start", 32'(alu_start), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic add: 3 + 5 with opcode 0.
        data_sw = 4'd3; press(1, 0, 12); model_step(); check_all("t1_a");
        data_sw = 4'd5; press(1, 0, 12); model_step(); check_all("t1_b");
        sel_sw = 6'b001111; press(1, 0, 12); model_step(); check_all("t1_op");
        check("t1_res8", 32'(result_out), 32'd8);
        check("t1_show", 32'(state_out), 32'(S_SHOW));
        press(1, 0, 12); model_step(); check_all("t1_back");

        // Invalid select then upper-bank opcode 12.
        data_sw = 4'd7; press(1, 0, 12); model_step();
        data_sw = 4'd2; press(1, 0, 12); model_step(); check_all("t2_b");
        sel_sw = 6'b000111; press(1, 0, 12); model_step(); check_all("t2_inv");
        check("t2_err", 32'(op_err), 32'd1);
        sel_sw = 6'b111110; press(1, 0, 12); model_step(); check_all("t2_op12");
        check("t2_op12v", 32'(alu_op), 32'd12);
        press(1, 0, 12); model_step();

        // Short glitch is rejected; a long hold gives one step only.
        btn_step_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_step_n = 1'b1;
        repeat (12) @(negedge clk);
        check_all("t3_glitch");
        data_sw = 4'd9; press(1, 0, 20); model_step(); check_all("t3_hold");
        check("t3_one_pulse", 32'(state_out), 32'(S_B));

        // Abort arrives the cycle after alu_start: no capture.
        data_sw = 4'd4; press(1, 0, 12); model_step();
        sel_sw = 6'b001111;
        saved_rises = rv_rises;
        btn_step_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_clr_n = 1'b0;
        repeat (12) @(negedge clk);
        btn_step_n = 1'b1; btn_clr_n = 1'b1;
        repeat (12) @(negedge clk);
        d = model_decode(sel_sw);
        m_op = d[3:0]; m_err = 0; m_starts = m_starts + 1;
        model_clr();
        check_all("t4_clr_exec");
        check("t4_no_valid", 32'(rv_rises), 32'(saved_rises));

        // Simultaneous step and abort in LOAD_B.
        data_sw = 4'd6; press(1, 0, 12); model_step(); check_all("t5_b");
        data_sw = 4'd11; press(1, 1, 12); model_clr(); check_all("t5_both");

        // Asynchronous reset in the middle of EXEC.
        data_sw = 4'd1; press(1, 0, 12); model_step();
        data_sw = 4'd2; press(1, 0, 12); model_step();
        sel_sw = 6'b011110;
        btn_step_n = 1'b0;
        for (int i = 0; i < 30 && !alu_start; i++) @(negedge clk);
        check("t6_start_seen", 32'(alu_start), 32'd1);
        #2;
        rst_n = 1'b0;
        btn_step_n = 1'b1;
        #1;
        model_reset();
        check_all("t6_in_reset");
        check("t6_start_low", 32'(alu_start), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_all("t6_after");

        // Random presses against the model.
        for (int t = 0; t < 40; t++) begin
            data_sw = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 4);
                s5 = 5'b11111;
                s5[4 - k] = 1'b0;
                sel_sw = {1'($urandom_range(0, 1)), s5};
            end else begin
                sel_sw = 6'($urandom);
            end
            r = $urandom_range(0, 7);
            if (r == 0) begin
                press(0, 1, 12);
                model_clr();
            end else begin
                press(1, 0, 12);
                model_step();
            end
            check_all("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
